// File: rtl/mul_div_unit_pkg.sv
// Shared op and state encodings for the multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    // True for the ops that treat operands as two's complement.
    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // True for the divide ops.
    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request / HI-LO bus between the pipeline and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_addsub.sv
// Shared W-bit add/subtract used by both the shift-add and shift-subtract steps.
// For subtract, cout=1 means no borrow (a >= b).
module mdu_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] res,
    output logic         cout
);
    // Single adder; subtract is a + ~b + 1.
    always_comb begin
        if (sub) begin
            {cout, res} = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        end else begin
            {cout, res} = {1'b0, a} + {1'b0, b};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   as_a, as_b, as_res;
    logic             as_sub, as_cout;

    mdu_addsub #(.W(WIDTH + 1)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .res  (as_res),
        .cout (as_cout)
    );

    // Adder operand selection for the current iteration step.
    always_comb begin
        if (op_is_div(op_q)) begin
            // Restoring divide: partial remainder shifted left with next dividend bit.
            as_a   = {acc_hi_q, acc_lo_q[WIDTH-1]};
            as_b   = {1'b0, b_q};
            as_sub = 1'b1;
        end else begin
            // Shift-add multiply: add multiplicand when the multiplier LSB is set.
            as_a   = {1'b0, acc_hi_q};
            as_b   = acc_lo_q[0] ? {1'b0, b_q} : '0;
            as_sub = 1'b0;
        end
    end

    logic             in1_neg, in2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [2*WIDTH-1:0] prod;
    mdu_op_e          req_op;

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        prod      = '0;

        req_op  = mdu_op_e'(bus.op);
        in1_neg = op_is_signed(req_op) && bus.in1[WIDTH-1];
        in2_neg = op_is_signed(req_op) && bus.in2[WIDTH-1];
        mag1    = in1_neg ? -bus.in1 : bus.in1;
        mag2    = in2_neg ? -bus.in2 : bus.in2;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d      = req_op;
                    neg_d     = in1_neg ^ in2_neg;
                    rem_neg_d = in1_neg;
                    count_d   = '0;
                    if (op_is_div(req_op) && (bus.in2 == '0)) begin
                        dz_d     = 1'b1;
                        acc_hi_d = bus.in1;
                        acc_lo_d = '1;
                        state_d  = ST_FIX;
                    end else begin
                        dz_d     = 1'b0;
                        acc_hi_d = '0;
                        acc_lo_d = op_is_div(req_op) ? mag1 : mag2;
                        b_d      = op_is_div(req_op) ? mag2 : mag1;
                        state_d  = ST_RUN;
                    end
                end else begin
                    if (bus.wr_hi) hi_d = bus.wr_data;
                    if (bus.wr_lo) lo_d = bus.wr_data;
                end
            end
            ST_RUN: begin
                if (op_is_div(op_q)) begin
                    acc_hi_d = as_cout ? as_res[WIDTH-1:0] : as_a[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], as_cout};
                end else begin
                    acc_hi_d = as_res[WIDTH:1];
                    acc_lo_d = {as_res[0], acc_lo_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dz_q) begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end else if (op_is_div(op_q)) begin
                    lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    prod = {acc_hi_q, acc_lo_q};
                    if (neg_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= MDU_MULT;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            b_q       <= b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
